// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS fetch path
// Purpose: instruction type codes, opcode constants and fetch FSM state encoding.
// Ports: none (package).
package mips_pkg;

  typedef enum logic [1:0] {
    IT_R    = 2'd0,
    IT_J    = 2'd1,
    IT_HALT = 2'd2,
    IT_I    = 2'd3
  } instr_type_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_FULL  = 2'd1,
    S_DROP  = 2'd2,
    S_HALT  = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_decode.sv
// rtl/if_decode.sv - combinational split of an instruction word into fields
// Purpose: field extraction plus instruction-type classification.
// Ports: instr (32b word in); opcode/rs/rt/rd/sa/funct/instr_address/immediate fields out; itype out.
module if_decode
  import mips_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input  logic [31:0]  instr,
  output logic [5:0]   opcode,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [4:0]   sa,
  output logic [5:0]   funct,
  output logic [25:0]  instr_address,
  output logic [15:0]  immediate,
  output instr_type_e  itype
);

  assign opcode        = instr[31:26];
  assign rs            = instr[25:21];
  assign rt            = instr[20:16];
  assign rd            = instr[15:11];
  assign sa            = instr[10:6];
  assign funct         = instr[5:0];
  assign instr_address = instr[25:0];
  assign immediate     = instr[15:0];

  always_comb begin
    itype = IT_I;
    if (opcode == OP_RTYPE)
      itype = IT_R;
    else if (opcode == OP_J || opcode == OP_JAL)
      itype = IT_J;
    else if (opcode == HALT_OPCODE)
      itype = IT_HALT;
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
// Purpose: PC register, fetch FSM over a one-outstanding req/ack memory port, one-entry skid buffer, IF/ID register.
// Ports: clk, rst_n; imem_req/imem_addr/imem_ack/imem_rdata memory port; stall, redirect_valid/redirect_pc from ID;
//        id_valid, id_pc, decoded fields and InstructionType to ID; halted status.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         id_valid,
  output logic [31:0]  id_pc,
  output logic [5:0]   opcode,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [4:0]   sa,
  output logic [5:0]   funct,
  output logic [25:0]  instr_address,
  output logic [15:0]  Adress_Immediate,
  output logic [1:0]   InstructionType,
  output logic         halted
);

  if_state_e   state, state_nxt;
  logic [31:0] pc;
  logic [31:0] drop_addr;   // address of the request being discarded after a redirect
  logic        skid_valid;
  logic [31:0] skid_word;
  logic [31:0] skid_pc;

  logic        fetch_ack, id_loadable, load_mem, load_skid, to_skid, id_load;
  logic [31:0] word_in, pc_in;

  logic [5:0]  dec_opcode, dec_funct;
  logic [4:0]  dec_rs, dec_rt, dec_rd, dec_sa;
  logic [25:0] dec_addr;
  logic [15:0] dec_imm;
  instr_type_e dec_type;

  // The old address is held in S_DROP so the memory sees a stable request until it acks.
  assign imem_req  = rst_n && (state == S_FETCH || state == S_DROP);
  assign imem_addr = (state == S_DROP) ? drop_addr : pc;
  assign halted    = (state == S_HALT);

  assign fetch_ack   = (state == S_FETCH) && imem_ack;
  assign id_loadable = !id_valid || !stall;
  assign load_mem    = fetch_ack && id_loadable;
  assign load_skid   = (state == S_FULL) && skid_valid && id_loadable;
  assign to_skid     = fetch_ack && !id_loadable;
  assign id_load     = load_mem || load_skid;
  assign word_in     = load_skid ? skid_word : imem_rdata;
  assign pc_in       = load_skid ? skid_pc : pc;

  if_decode #(.HALT_OPCODE(HALT_OPCODE)) u_decode (
    .instr         (word_in),
    .opcode        (dec_opcode),
    .rs            (dec_rs),
    .rt            (dec_rt),
    .rd            (dec_rd),
    .sa            (dec_sa),
    .funct         (dec_funct),
    .instr_address (dec_addr),
    .immediate     (dec_imm),
    .itype         (dec_type)
  );

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      // An unacked request must still be drained; an ack this cycle completes it.
      if ((state == S_FETCH || state == S_DROP) && !imem_ack)
        state_nxt = S_DROP;
      else
        state_nxt = S_FETCH;
    end else begin
      case (state)
        S_FETCH: if (imem_ack)
                   state_nxt = to_skid ? S_FULL : ((dec_type == IT_HALT) ? S_HALT : S_FETCH);
        S_FULL:  if (load_skid)
                   state_nxt = (dec_type == IT_HALT) ? S_HALT : S_FETCH;
        S_DROP:  if (imem_ack) state_nxt = S_FETCH;
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_FETCH;
      pc               <= RESET_PC;
      drop_addr        <= '0;
      skid_valid       <= 1'b0;
      skid_word        <= '0;
      skid_pc          <= '0;
      id_valid         <= 1'b0;
      id_pc            <= '0;
      opcode           <= '0;
      rs               <= '0;
      rt               <= '0;
      rd               <= '0;
      sa               <= '0;
      funct            <= '0;
      instr_address    <= '0;
      Adress_Immediate <= '0;
      InstructionType  <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc         <= redirect_pc & 32'hFFFF_FFFC;
        skid_valid <= 1'b0;
        id_valid   <= 1'b0;
        if (state == S_FETCH)
          drop_addr <= pc;
      end else begin
        if (fetch_ack)
          pc <= pc + 32'd4;
        if (to_skid) begin
          skid_valid <= 1'b1;
          skid_word  <= imem_rdata;
          skid_pc    <= pc;
        end else if (load_skid) begin
          skid_valid <= 1'b0;
        end
        if (id_load) begin
          id_valid         <= 1'b1;
          id_pc            <= pc_in;
          opcode           <= dec_opcode;
          rs               <= dec_rs;
          rt               <= dec_rt;
          rd               <= dec_rd;
          sa               <= dec_sa;
          funct            <= dec_funct;
          instr_address    <= dec_addr;
          Adress_Immediate <= dec_imm;
          InstructionType  <= dec_type;
        end else if (!stall) begin
          id_valid <= 1'b0;
        end
      end
    end
  end

endmodule
